// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   - RV32I funct3 width codes (F3_B, F3_H, F3_W, F3_BU, F3_HU)
//   - lsu_state_t: control FSM state encoding
//   - is_misaligned(): alignment check for a width code and the low address bits
//   - is_illegal(): rejects width codes that are not legal for the access type
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StStoreRd,
        StStoreWr,
        StResp
    } lsu_state_t;

    // Halfwords must be 2-byte aligned, words 4-byte aligned; bytes never fault.
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] lo);
        logic mis;
        mis = 1'b0;
        case (funct3)
            F3_H, F3_HU: mis = lo[0];
            F3_W:        mis = (lo != 2'b00);
            default:     mis = 1'b0;
        endcase
        return mis;
    endfunction

    // Stores only have B/H/W; loads additionally have BU/HU.
    function automatic logic is_illegal(input logic store, input logic [2:0] funct3);
        logic ill;
        ill = 1'b0;
        case (funct3)
            F3_B, F3_H, F3_W: ill = 1'b0;
            F3_BU, F3_HU:     ill = store;
            default:          ill = 1'b1;
        endcase
        return ill;
    endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// lsu_byte_lane: combinational data path of the load/store unit.
//   funct3     in  width code of the access
//   lane       in  byte offset within the word (addr[1:0])
//   rdata      in  word read from memory (old word for stores)
//   wdata      in  store data from the core
//   load_data  out extracted and sign/zero-extended load result
//   store_data out old word with the addressed byte/half replaced (or wdata for SW)
module lsu_byte_lane
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  lane,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[7:0];
        case (lane)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = lane[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        load_data = 32'h0;
        case (funct3)
            F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
            F3_W:    load_data = rdata;
            F3_BU:   load_data = {24'h0, byte_sel};
            F3_HU:   load_data = {16'h0, half_sel};
            default: load_data = 32'h0;
        endcase
    end

    always_comb begin
        store_data = rdata;
        case (funct3)
            F3_B: begin
                case (lane)
                    2'd0:    store_data[7:0]   = wdata[7:0];
                    2'd1:    store_data[15:8]  = wdata[7:0];
                    2'd2:    store_data[23:16] = wdata[7:0];
                    default: store_data[31:24] = wdata[7:0];
                endcase
            end
            F3_H: begin
                if (lane[1]) begin
                    store_data[31:16] = wdata[15:0];
                end else begin
                    store_data[15:0] = wdata[15:0];
                end
            end
            F3_W:    store_data = wdata;
            default: store_data = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: converts byte-addressed RV32I loads/stores into accesses on a
// word-only memory (combinational read, synchronous write, no byte enables).
// Sub-word stores are done as read-modify-write.
//
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   req_valid_i / req_ready_o     request handshake (ready only while idle)
//   req_store_i, req_funct3_i     access type and width code
//   req_addr_i, req_wdata_i       byte address and store data
//   resp_valid_o                  one-cycle completion pulse
//   resp_rdata_o, resp_err_o      extended load data / error flag
//   mem_addr_o, mem_we_o,
//   mem_wdata_o, mem_rdata_i      word-addressed memory interface
//
// Configuration macro: LSU_BOUNDS_CHECK_EN -- when defined, any address with bits
// above the memory range set is rejected as an error instead of wrapping.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 8,
    parameter logic [31:0] RESET_ADDR = 32'h0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_store_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o,
    output logic [31:0] mem_addr_o,
    output logic        mem_we_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i
);

    lsu_state_t  state;
    logic [2:0]  lat_funct3;
    logic [1:0]  lat_lane;
    logic [31:0] lat_wdata;

    logic [31:0] word_index;
    logic        out_of_range;
    logic        req_err;
    logic [31:0] load_data;
    logic [31:0] store_data;

    assign word_index = {{(32 - DEPTH_LOG2){1'b0}}, req_addr_i[DEPTH_LOG2+1:2]};

`ifdef LSU_BOUNDS_CHECK_EN
    assign out_of_range = |req_addr_i[31:DEPTH_LOG2+2];
`else
    // Upper address bits are intentionally dropped so accesses alias.
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr_i[31:DEPTH_LOG2+2];
    assign out_of_range   = 1'b0;
`endif

    assign req_err = is_misaligned(req_funct3_i, req_addr_i[1:0])
                   | is_illegal(req_store_i, req_funct3_i)
                   | out_of_range;

    assign req_ready_o = (state == StIdle);

    lsu_byte_lane u_byte_lane (
        .funct3     (lat_funct3),
        .lane       (lat_lane),
        .rdata      (mem_rdata_i),
        .wdata      (lat_wdata),
        .load_data  (load_data),
        .store_data (store_data)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= StIdle;
            lat_funct3   <= 3'b000;
            lat_lane     <= 2'b00;
            lat_wdata    <= 32'h0;
            resp_valid_o <= 1'b0;
            resp_rdata_o <= 32'h0;
            resp_err_o   <= 1'b0;
            mem_addr_o   <= RESET_ADDR;
            mem_we_o     <= 1'b0;
            mem_wdata_o  <= 32'h0;
        end else begin
            case (state)
                StIdle: begin
                    if (req_valid_i) begin
                        lat_funct3 <= req_funct3_i;
                        lat_lane   <= req_addr_i[1:0];
                        lat_wdata  <= req_wdata_i;
                        if (req_err) begin
                            // Errors never touch memory; the address stays parked.
                            state        <= StResp;
                            resp_valid_o <= 1'b1;
                            resp_err_o   <= 1'b1;
                            resp_rdata_o <= 32'h0;
                        end else if (!req_store_i) begin
                            state      <= StLoad;
                            mem_addr_o <= word_index;
                        end else if (req_funct3_i == F3_W) begin
                            // Full-word stores skip the read phase.
                            state       <= StStoreWr;
                            mem_addr_o  <= word_index;
                            mem_we_o    <= 1'b1;
                            mem_wdata_o <= req_wdata_i;
                        end else begin
                            state      <= StStoreRd;
                            mem_addr_o <= word_index;
                        end
                    end
                end
                StLoad: begin
                    state        <= StResp;
                    resp_valid_o <= 1'b1;
                    resp_err_o   <= 1'b0;
                    resp_rdata_o <= load_data;
                end
                StStoreRd: begin
                    state       <= StStoreWr;
                    mem_we_o    <= 1'b1;
                    mem_wdata_o <= store_data;
                end
                StStoreWr: begin
                    state        <= StResp;
                    mem_we_o     <= 1'b0;
                    resp_valid_o <= 1'b1;
                    resp_err_o   <= 1'b0;
                    resp_rdata_o <= 32'h0;
                end
                StResp: begin
                    state        <= StIdle;
                    resp_valid_o <= 1'b0;
                    resp_err_o   <= 1'b0;
                    resp_rdata_o <= 32'h0;
                    mem_addr_o   <= RESET_ADDR;
                end
                default: begin
                    state    <= StIdle;
                    mem_we_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural word memory.
module tb_load_store_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_store_i;
    logic [2:0]  req_funct3_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic        resp_valid_o;
    logic [31:0] resp_rdata_o;
    logic        resp_err_o;
    logic [31:0] mem_addr_o;
    logic        mem_we_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;

    logic [31:0] mem [0:255];

    int errors = 0;
    int checks = 0;

    always #5 clk_i = ~clk_i;

    assign mem_rdata_i = mem[mem_addr_o[7:0]];

    always @(posedge clk_i) begin
        if (mem_we_o) mem[mem_addr_o[7:0]] <= mem_wdata_o;
    end

    load_store_unit #(
        .DEPTH_LOG2 (8),
        .RESET_ADDR (32'h0)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_store_i  (req_store_i),
        .req_funct3_i (req_funct3_i),
        .req_addr_i   (req_addr_i),
        .req_wdata_i  (req_wdata_i),
        .resp_valid_o (resp_valid_o),
        .resp_rdata_o (resp_rdata_o),
        .resp_err_o   (resp_err_o),
        .mem_addr_o   (mem_addr_o),
        .mem_we_o     (mem_we_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_rdata_i  (mem_rdata_i)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request and follow it to its response (bounded to 6 cycles).
    task automatic txn(input string tag, input logic store, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input int exp_lat, input logic [31:0] exp_rdata, input logic exp_err,
                       input int exp_wcnt, input logic [31:0] exp_waddr,
                       input logic [31:0] exp_wdata);
        int lat;
        int wcnt;
        logic [31:0] waddr;
        logic [31:0] wdat;
        lat = 0;
        wcnt = 0;
        waddr = 32'h0;
        wdat = 32'h0;
        @(negedge clk_i);
        chk({tag, " ready"}, {31'h0, req_ready_o}, 32'h1);
        req_valid_i  = 1'b1;
        req_store_i  = store;
        req_funct3_i = f3;
        req_addr_i   = addr;
        req_wdata_i  = wdata;
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
        req_wdata_i = 32'h0;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            @(negedge clk_i);
            if (mem_we_o) begin
                wcnt++;
                waddr = mem_addr_o;
                wdat  = mem_wdata_o;
            end
            if (resp_valid_o) begin
                lat = cyc;
                chk({tag, " rdata"}, resp_rdata_o, exp_rdata);
                chk({tag, " err"}, {31'h0, resp_err_o}, {31'h0, exp_err});
                break;
            end
        end
        chk({tag, " latency"}, lat, exp_lat);
        chk({tag, " we_count"}, wcnt, exp_wcnt);
        if (exp_wcnt > 0) begin
            chk({tag, " waddr"}, waddr, exp_waddr);
            chk({tag, " wdata"}, wdat, exp_wdata);
        end
        @(negedge clk_i);
        chk({tag, " idle_ready"}, {31'h0, req_ready_o}, 32'h1);
        chk({tag, " idle_valid"}, {31'h0, resp_valid_o}, 32'h0);
        chk({tag, " idle_addr"}, mem_addr_o, 32'h0);
    endtask

    initial begin
        int seen_we;
        int seen_resp;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[1] = 32'hAFAFAFAF;
        mem[2] = 32'h12345678;
        rst_i        = 1'b1;
        req_valid_i  = 1'b0;
        req_store_i  = 1'b0;
        req_funct3_i = 3'b000;
        req_addr_i   = 32'h0;
        req_wdata_i  = 32'h0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst ready", {31'h0, req_ready_o}, 32'h1);
        chk("rst valid", {31'h0, resp_valid_o}, 32'h0);
        chk("rst rdata", resp_rdata_o, 32'h0);
        chk("rst err", {31'h0, resp_err_o}, 32'h0);
        chk("rst we", {31'h0, mem_we_o}, 32'h0);
        chk("rst wdata", mem_wdata_o, 32'h0);
        chk("rst addr", mem_addr_o, 32'h0);
        rst_i = 1'b0;

        //   tag      st   f3      addr   wdata  lat rdata   err wcnt waddr wdata
        txn("lb5",   0, 3'b000, 32'h05, 32'h0, 2, 32'hFFFFFFAF, 0, 0, 0, 0);
        txn("lbu5",  0, 3'b100, 32'h05, 32'h0, 2, 32'h000000AF, 0, 0, 0, 0);
        txn("sb6",   1, 3'b000, 32'h06, 32'h12, 3, 32'h0, 0, 1, 32'h1, 32'hAF12AFAF);
        txn("lw4",   0, 3'b010, 32'h04, 32'h0, 2, 32'hAF12AFAF, 0, 0, 0, 0);
        txn("lb7",   0, 3'b000, 32'h07, 32'h0, 2, 32'hFFFFFFAF, 0, 0, 0, 0);
        txn("lb6",   0, 3'b000, 32'h06, 32'h0, 2, 32'h00000012, 0, 0, 0, 0);
        txn("sha",   1, 3'b001, 32'h0A, 32'h8001, 3, 32'h0, 0, 1, 32'h2, 32'h80015678);
        txn("lha",   0, 3'b001, 32'h0A, 32'h0, 2, 32'hFFFF8001, 0, 0, 0, 0);
        txn("lhua",  0, 3'b101, 32'h0A, 32'h0, 2, 32'h00008001, 0, 0, 0, 0);
        txn("lhu8",  0, 3'b101, 32'h08, 32'h0, 2, 32'h00005678, 0, 0, 0, 0);
        txn("lw3",   0, 3'b010, 32'h03, 32'h0, 1, 32'h0, 1, 0, 0, 0);
        txn("sh1",   1, 3'b001, 32'h01, 32'hFFFF, 1, 32'h0, 1, 0, 0, 0);
        txn("ld011", 0, 3'b011, 32'h00, 32'h0, 1, 32'h0, 1, 0, 0, 0);
        txn("st100", 1, 3'b100, 32'h00, 32'h55, 1, 32'h0, 1, 0, 0, 0);
`ifdef LSU_BOUNDS_CHECK_EN
        txn("sw400", 1, 3'b010, 32'h400, 32'hDEADBEEF, 1, 32'h0, 1, 0, 0, 0);
        txn("lw0",   0, 3'b010, 32'h00, 32'h0, 2, 32'h00000000, 0, 0, 0, 0);
`else
        txn("sw400", 1, 3'b010, 32'h400, 32'hDEADBEEF, 2, 32'h0, 0, 1, 32'h0, 32'hDEADBEEF);
        txn("lw0",   0, 3'b010, 32'h00, 32'h0, 2, 32'hDEADBEEF, 0, 0, 0, 0);
`endif

        // Reset while the SB read phase is in progress.
        @(negedge clk_i);
        req_valid_i  = 1'b1;
        req_store_i  = 1'b1;
        req_funct3_i = 3'b000;
        req_addr_i   = 32'h08;
        req_wdata_i  = 32'hEE;
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
        @(negedge clk_i);
        chk("abort busy", {31'h0, req_ready_o}, 32'h0);
        chk("abort we_rd", {31'h0, mem_we_o}, 32'h0);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        seen_we = 0;
        seen_resp = 0;
        @(negedge clk_i);
        chk("abort ready", {31'h0, req_ready_o}, 32'h1);
        for (int c = 0; c < 4; c++) begin
            if (mem_we_o) seen_we++;
            if (resp_valid_o) seen_resp++;
            @(negedge clk_i);
        end
        chk("abort no_we", seen_we, 0);
        chk("abort no_resp", seen_resp, 0);
        txn("lw8",   0, 3'b010, 32'h08, 32'h0, 2, 32'h80015678, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Core-side initiator for the word-addressed data memory: accepts byte-addressed RV32I load and store requests, converts them to word accesses, and drives the memory's address, write-enable and write-data pins.
- The memory is word-only (read is combinational, write is synchronous, no byte enables). Sub-word stores (SB/SH) are therefore done as a read-modify-write sequence. Loads are extracted and sign- or zero-extended before being returned.
- Sits between the execute stage and data memory.

Parameters:
- DEPTH_LOG2, 8, log2 of memory depth in 32-bit words.
- RESET_ADDR, 32'h0, value driven on mem_addr_o while idle or in reset.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  unit can accept a request this cycle.
- req_store_i  in  1  1 = store, 0 = load.
- req_funct3_i  in  3  RV32I width code: LB=000, LH=001, LW=010, LBU=100, LHU=101, SB=000, SH=001, SW=010.
- req_addr_i  in  32  byte address.
- req_wdata_i  in  32  store data; only the low byte or low half is used for SB/SH.
- resp_valid_o  out  1  one-cycle completion pulse.
- resp_rdata_o  out  32  extended load data; 0 for stores and for errors.
- resp_err_o  out  1  misaligned access or illegal funct3; valid only with resp_valid_o.
- mem_addr_o  out  32  word index to memory: {zeros, addr[DEPTH_LOG2+1:2]}.
- mem_we_o  out  1  memory write enable.
- mem_wdata_o  out  32  memory write data.
- mem_rdata_i  in  32  memory combinational read data.

Behaviour:
- Clock and reset: clk_i is the only clock. rst_i is synchronous and active-high.
- Reset values: state=IDLE, req_ready_o=1, resp_valid_o=0, resp_rdata_o=0, resp_err_o=0, mem_we_o=0, mem_wdata_o=0, mem_addr_o=RESET_ADDR.
- Handshake and capture:
  - req_ready_o = (state==IDLE). A transfer occurs when valid&&ready at a rising edge.
  - On a transfer, store, funct3, addr and wdata are latched. Inputs are ignored while busy.
- States:
  - IDLE
  - LOAD: drive address; capture mem_rdata_i at the edge.
  - STORE_RD: drive address; capture the old word at the edge.
  - STORE_WR: mem_we_o=1 for exactly this cycle; mem_wdata_o holds the merged word.
  - RESP: resp_valid_o=1 for one cycle.
- Transitions:
  - IDLE → LOAD for a load.
  - IDLE → STORE_WR for SW.
  - IDLE → STORE_RD for SB/SH.
  - IDLE → RESP for an error.
  - LOAD → RESP.
  - STORE_RD → STORE_WR.
  - STORE_WR → RESP.
  - RESP → IDLE.
- Latency from the accept edge to resp_valid_o high:
  - Loads: 2 cycles.
  - SW: 2 cycles.
  - SB/SH: 3 cycles.
  - Errors: 1 cycle, with no memory access.
  - Back-to-back throughput: one request per latency+1 cycles.
- Misalignment:
  - Halfword with addr[0]=1 is an error.
  - Word with addr[1:0]!=0 is an error.
  - funct3 011, 110 or 111, and store funct3 ≥ 011, are errors.
  - On error: resp_err_o=1, resp_rdata_o=0, mem_we_o never asserted.
- Load extraction (lane = addr[1:0]):
  - Byte: mem_rdata[8*lane+:8].
  - Half: mem_rdata[16*addr[1]+:16].
  - LB/LH sign-extend; LBU/LHU zero-extend.
- Store merge:
  - SB replaces bits [8*lane+:8] of the old word with wdata[7:0].
  - SH replaces [16*addr[1]+:16] with wdata[15:0].
  - SW writes wdata unchanged.
- Address wrap: address bits above DEPTH_LOG2+1 are ignored, so accesses alias modulo memory size.
- Reset mid-operation: returns to IDLE at that edge and mem_we_o=0. An aborted RMW leaves memory unmodified, because a write only happens in STORE_WR. No response is issued for the aborted request.
- Outside STORE_WR: mem_we_o=0 and mem_wdata_o holds its last value.

Optional Feature:
- Macro: LSU_BOUNDS_CHECK_EN.
- Defined: any request with addr[31:DEPTH_LOG2+2] nonzero is an error. It goes IDLE→RESP, asserts resp_err_o, and performs no memory access.
- Undefined: the upper address bits are ignored and accesses wrap as above.

Decomposition:
- Package lsu_pkg:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - State enum lsu_state_t.
  - Function is_misaligned(funct3, addr[1:0]).
- Sub-module lsu_byte_lane: purely combinational. Inputs are funct3, lane, old/read word and store data. Outputs are the extended load data and the merged store word. It is instantiated once.

Test Plan:
- Memory word 1 = 32'hAFAFAFAF; LB addr 0x05 → resp_rdata_o=32'hFFFFFFAF two cycles after accept; LBU addr 0x05 → 32'h000000AF; mem_we_o never high.
- SB addr 0x06, wdata 32'h00000012 → one mem_we_o pulse at word 1 with mem_wdata_o=32'hAF12AFAF; resp_valid_o 3 cycles after accept; subsequent LW 0x04 → 32'hAF12AFAF.
- SH addr 0x0A, wdata 32'h00008001, then LH 0x0A → 32'hFFFF8001; LHU 0x0A → 32'h00008001; low half of word 2 unchanged.
- LW addr 0x03 and SH addr 0x01 → resp_err_o=1 one cycle after accept; resp_rdata_o=0; no mem_we_o; ready returns the following cycle.
- rst_i asserted while in STORE_RD of SB 0x08 → next cycle state IDLE, req_ready_o=1, mem_we_o never asserted, word 2 unchanged, no resp_valid_o.
- With LSU_BOUNDS_CHECK_EN defined: SW addr 0x400 → resp_err_o=1, no write. Without it: SW addr 0x400, wdata 32'hDEADBEEF → word 0 written 32'hDEADBEEF.
